wb_arbiter_6to4: RTL and testbench
==================================

WB_ARBITER_6TO4 -- requirements
Module: wb_arbiter_6to4

Interface
REQ-001 SHALL have parameters: NSRC, 6, number of execution-unit result sources.
REQ-002 SHALL have parameters: NWP, 4, number of register-file write ports driven.
REQ-003 SHALL have parameters: PREG_W, 7, physical register tag width; XLEN, 64, data width.
REQ-004 SHALL have port: clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: src_valid  in  NSRC  per-source result valid.
REQ-007 SHALL have port: src_ready  out  NSRC  per-source accept (combinational).
REQ-008 SHALL have port: src_preg  in  NSRC*PREG_W  destination physical register per source.
REQ-009 SHALL have port: src_data  in  NSRC*XLEN  result data per source.
REQ-010 SHALL have port: flush  in  1  synchronous pipeline flush.
REQ-011 SHALL have port: wp_we  out  NWP  registered write enables to physical register file.
REQ-012 SHALL have port: wp_addr  out  NWP*PREG_W  registered write addresses.
REQ-013 SHALL have port: wp_data  out  NWP*XLEN  registered write data.
REQ-014 SHALL have port: dup_err  out  1  sticky error, same preg granted twice in one cycle.
REQ-015 SHALL have port: stall_cnt  out  32  saturating count of cycles with an ungranted valid source.

Function
REQ-016 SHALL transfer a source result when src_valid[i] and src_ready[i] are both high at a rising edge.
REQ-017 SHALL compute grants combinationally: scan sources from rr_ptr upward modulo NSRC, granting the first up to NWP valid sources.
REQ-018 SHALL drive src_ready[i] = grant[i]; src_ready SHALL depend only on src_valid, rr_ptr and flush.
REQ-019 SHALL map the k-th grant in scan order (k=0..NWP-1) to write port k; unused ports SHALL have we=0.
REQ-020 SHALL register granted preg/data onto wp_addr/wp_data and set wp_we one cycle after the handshake (latency 1).
REQ-021 SHALL hold wp_addr/wp_data unchanged on ports whose wp_we is 0.
REQ-022 SHALL accept (ready=1) a granted source with preg 0 but SHALL NOT assert wp_we for it (zero register never written).
REQ-023 SHALL update rr_ptr on any cycle with >=1 grant to (index of last granted source + 1) mod NSRC; otherwise hold.
REQ-024 SHALL, with flush high, force src_ready to 0, clear all wp_we at the next edge, and hold rr_ptr.
REQ-025 SHALL set dup_err when two granted sources in one cycle carry equal nonzero preg; both still written; dup_err stays 1 until reset.
REQ-026 SHALL increment stall_cnt on each cycle (flush low) where any src_valid is high with its src_ready low; saturate at 0xFFFFFFFF.
REQ-027 SHALL NOT count flush cycles in stall_cnt.
REQ-028 SHALL grant all valid sources when <=NWP are valid, with no stall counted.

Reset
REQ-029 SHALL, while rst_n low, clear wp_we, wp_addr, wp_data, dup_err, stall_cnt and set rr_ptr to 0.
REQ-030 SHALL hold src_ready at 0 while rst_n is low.
REQ-031 SHALL drop any result registered before an asynchronous reset asserted mid-operation; no write after reset release without a new handshake.

Verification
REQ-032 SHALL test: rr_ptr=0, sources 0,2,5 valid (preg 10,11,12) -> ready=0b100101; next cycle wp_we=0b0111, wp_addr={12,11,10} on ports 2..0; rr_ptr=0.
REQ-033 SHALL test: all 6 valid, rr_ptr=0 -> grants 0..3, stall_cnt+1, rr_ptr=4; next cycle, all 6 valid again -> grants 4,5,0,1 on ports 0..3, rr_ptr=2.
REQ-034 SHALL test: source 1 preg 0 valid alone -> src_ready[1]=1, next cycle wp_we=0.
REQ-035 SHALL test: sources 0 and 3 both preg 7 -> both written on ports 0,1, dup_err=1 persists until rst_n low.
REQ-036 SHALL test: flush high with 6 valid -> src_ready=0, wp_we=0 next cycle, stall_cnt and rr_ptr unchanged.
REQ-037 SHALL test: stall_cnt forced near 0xFFFFFFFF, 3 further stall cycles -> holds 0xFFFFFFFF; rst_n pulse -> 0.

Source files
------------

// File: rtl/wb_arbiter_6to4.sv
// wb_arbiter_6to4: round-robin arbiter steering up to NWP of NSRC execution results
// onto registered physical register file write ports.
module wb_arbiter_6to4 #(
    parameter int NSRC   = 6,
    parameter int NWP    = 4,
    parameter int PREG_W = 7,
    parameter int XLEN   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NSRC-1:0]        src_valid,
    output logic [NSRC-1:0]        src_ready,
    input  logic [NSRC*PREG_W-1:0] src_preg,
    input  logic [NSRC*XLEN-1:0]   src_data,
    input  logic                   flush,
    output logic [NWP-1:0]         wp_we,
    output logic [NWP*PREG_W-1:0]  wp_addr,
    output logic [NWP*XLEN-1:0]    wp_data,
    output logic                   dup_err,
    output logic [31:0]            stall_cnt
);
    localparam int IW = $clog2(NSRC);

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     rr_nxt;
    logic [NSRC-1:0]   grant;
    logic [NWP-1:0]    pv;
    logic [PREG_W-1:0] pp [NWP];
    logic [XLEN-1:0]   pd [NWP];
    logic              dup;
    logic              stall;

    // n counts grants so far; the n-th grant in scan order lands on write port n
    always_comb begin
        int n;
        int idx;
        grant  = '0;
        pv     = '0;
        rr_nxt = rr_ptr;
        n      = 0;
        idx    = 0;
        for (int p = 0; p < NWP; p++) begin
            pp[p] = '0;
            pd[p] = '0;
        end
        for (int o = 0; o < NSRC; o++) begin
            idx = (int'(rr_ptr) + o) % NSRC;
            if (src_valid[idx] && !flush && n < NWP) begin
                grant[idx] = 1'b1;
                pv[n]      = 1'b1;
                pp[n]      = src_preg[idx*PREG_W +: PREG_W];
                pd[n]      = src_data[idx*XLEN +: XLEN];
                rr_nxt     = IW'((idx + 1) % NSRC);
                n++;
            end
        end
    end

    always_comb begin
        dup = 1'b0;
        for (int p = 0; p < NWP; p++)
            for (int q = p + 1; q < NWP; q++)
                if (pv[p] && pv[q] && |pp[p] && pp[p] == pp[q]) dup = 1'b1;
    end

    assign src_ready = rst_n ? grant : '0;
    assign stall     = !flush && |(src_valid & ~grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_we     <= '0;
            wp_addr   <= '0;
            wp_data   <= '0;
            rr_ptr    <= '0;
            dup_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            // preg 0 is the hardwired zero register: accepted but never written
            for (int p = 0; p < NWP; p++) begin
                wp_we[p] <= pv[p] && |pp[p];
                if (pv[p] && |pp[p]) begin
                    wp_addr[p*PREG_W +: PREG_W] <= pp[p];
                    wp_data[p*XLEN +: XLEN]     <= pd[p];
                end
            end
            rr_ptr  <= rr_nxt;
            dup_err <= dup_err | dup;
            if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter_6to4.sv
// tb_wb_arbiter_6to4: directed and random stimulus against a queue-based grant model.
module tb_wb_arbiter_6to4;
    localparam int NSRC = 6;
    localparam int NWP  = 4;
    localparam int PW   = 7;
    localparam int XL   = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NSRC-1:0]      src_valid = '0;
    logic [NSRC-1:0]      src_ready;
    logic [NSRC*PW-1:0]   src_preg = '0;
    logic [NSRC*XL-1:0]   src_data = '0;
    logic                 flush = 1'b0;
    logic [NWP-1:0]       wp_we;
    logic [NWP*PW-1:0]    wp_addr;
    logic [NWP*XL-1:0]    wp_data;
    logic                 dup_err;
    logic [31:0]          stall_cnt;

    wb_arbiter_6to4 dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
        .src_preg(src_preg), .src_data(src_data), .flush(flush), .wp_we(wp_we),
        .wp_addr(wp_addr), .wp_data(wp_data), .dup_err(dup_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [PW-1:0] sp [NSRC];
    logic [XL-1:0] sd [NSRC];
    int            m_rr;
    logic [31:0]   m_stall;
    logic          m_dup;
    logic [NWP-1:0] m_we;
    logic [PW-1:0] m_addr [NWP];
    logic [XL-1:0] m_data [NWP];
    logic [NSRC-1:0] got_ready;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NWP*PW-1:0] ea;
        logic [NWP*XL-1:0] ed;
        for (int p = 0; p < NWP; p++) begin
            ea[p*PW +: PW] = m_addr[p];
            ed[p*XL +: XL] = m_data[p];
        end
        check({tag, "_we"}, 256'(wp_we), 256'(m_we));
        check({tag, "_addr"}, 256'(wp_addr), 256'(ea));
        check({tag, "_data"}, 256'(wp_data), 256'(ed));
        check({tag, "_dup"}, 256'(dup_err), 256'(m_dup));
        check({tag, "_stall"}, 256'(stall_cnt), 256'(m_stall));
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic step(input logic [NSRC-1:0] v, input logic f);
        int g[$];
        int i;
        logic [NSRC-1:0] er;
        src_valid = v;
        flush     = f;
        for (int s = 0; s < NSRC; s++) begin
            src_preg[s*PW +: PW] = sp[s];
            src_data[s*XL +: XL] = sd[s];
        end
        #1;
        got_ready = src_ready;
        er = '0;
        for (int o = 0; o < NSRC; o++) begin
            i = (m_rr + o) % NSRC;
            if (v[i] && !f && g.size() < NWP) begin
                g.push_back(i);
                er[i] = 1'b1;
            end
        end
        check("ready", 256'(src_ready), 256'(er));
        m_we = '0;
        for (int k = 0; k < g.size(); k++)
            if (sp[g[k]] != 0) begin
                m_we[k]   = 1'b1;
                m_addr[k] = sp[g[k]];
                m_data[k] = sd[g[k]];
            end
        for (int a = 0; a < g.size(); a++)
            for (int b = a + 1; b < g.size(); b++)
                if (sp[g[a]] != 0 && sp[g[a]] == sp[g[b]]) m_dup = 1'b1;
        if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NSRC;
        if (!f && v != er && m_stall != 32'hFFFF_FFFF) m_stall++;
        @(posedge clk);
        @(negedge clk);
        check_outputs("step");
    endtask

    task automatic do_reset();
        src_valid = '1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 256'(src_ready), 256'(0));
        check("rst_we_async", 256'(wp_we), 256'(0));
        @(posedge clk);
        @(negedge clk);
        m_rr = 0;
        m_stall = '0;
        m_dup = 1'b0;
        m_we = '0;
        for (int p = 0; p < NWP; p++) begin
            m_addr[p] = '0;
            m_data[p] = '0;
        end
        check_outputs("rst");
        src_valid = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int s = 0; s < NSRC; s++) begin
            sp[s] = PW'(s + 1);
            sd[s] = {$urandom, $urandom};
        end
        @(negedge clk);
        do_reset();

        sp[0] = 7'd10; sp[2] = 7'd11; sp[5] = 7'd12;
        step(6'b100101, 1'b0);
        check("s32_ready", 256'(got_ready), 256'(6'b100101));
        check("s32_we", 256'(wp_we), 256'(4'b0111));
        check("s32_addr", 256'(wp_addr[20:0]), 256'({7'd12, 7'd11, 7'd10}));

        for (int s = 0; s < NSRC; s++) sp[s] = PW'(20 + s);
        step(6'h3f, 1'b0);
        check("s33a_ready", 256'(got_ready), 256'(6'b001111));
        check("s33a_stall", 256'(stall_cnt), 256'(1));
        step(6'h3f, 1'b0);
        check("s33b_ready", 256'(got_ready), 256'(6'b110011));
        check("s33b_addr", 256'(wp_addr), 256'({7'd21, 7'd20, 7'd25, 7'd24}));
        step(6'h3f, 1'b0);
        check("s33c_ready", 256'(got_ready), 256'(6'b111100));

        do_reset();
        sp[1] = 7'd0;
        step(6'b000010, 1'b0);
        check("s34_ready", 256'(got_ready), 256'(6'b000010));
        check("s34_we", 256'(wp_we), 256'(0));

        sp[0] = 7'd7; sp[3] = 7'd7;
        step(6'b001001, 1'b0);
        check("s35_we", 256'(wp_we[1:0]), 256'(2'b11));
        check("s35_dup", 256'(dup_err), 256'(1));
        sp[3] = 7'd8;
        step(6'b001001, 1'b0);
        step(6'b000000, 1'b0);
        check("s35_sticky", 256'(dup_err), 256'(1));
        do_reset();
        check("s35_clr", 256'(dup_err), 256'(0));

        step(6'b000011, 1'b0);
        step(6'h3f, 1'b1);
        check("s36_ready", 256'(got_ready), 256'(0));
        check("s36_we", 256'(wp_we), 256'(0));
        step(6'h3f, 1'b0);

        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        m_stall = 32'hFFFF_FFFD;
        for (int k = 0; k < 3; k++) step(6'h3f, 1'b0);
        check("s37_sat", 256'(stall_cnt), 256'(32'hFFFF_FFFF));
        do_reset();
        check("s37_clr", 256'(stall_cnt), 256'(0));

        for (int t = 0; t < 400; t++) begin
            for (int s = 0; s < NSRC; s++) begin
                sp[s] = PW'($urandom_range(0, 15));
                sd[s] = {$urandom, $urandom};
            end
            if ($urandom_range(0, 49) == 0) do_reset();
            else step(NSRC'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
